ext_int_responder: RTL and testbench

//  CPU-side responder for the external-interrupt handshake. Samples the external

---
 rtl/ext_int_responder_pkg.sv | 21 ++
 rtl/ext_int_responder_if.sv | 22 ++
 rtl/ext_int_responder_ack_timeout_ctr.sv | 32 +++
 rtl/ext_int_responder.sv | 138 +++++++++++++
 tb/tb_ext_int_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_int_responder_pkg.sv
// Shared constants for the external-interrupt responder: FSM encoding, register map
// offsets and the CP0 interrupt line it drives.
package ext_int_responder_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PENDING  = 2'd1;
  localparam logic [1:0] ST_SERVICE  = 2'd2;
  localparam logic [1:0] ST_ACK_WAIT = 2'd3;

  localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7F20;
  localparam logic [31:0] OFS_ACK          = 32'd0;
  localparam logic [31:0] OFS_CNT          = 32'd4;
  localparam logic [31:0] OFS_EN           = 32'd8;

  localparam int HWINT_IDX = 2;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ext_int_responder_if.sv
// Interrupt line, CP0 handshake and data-bus slave signals of the responder.
interface ext_int_responder_if;
  logic        int_in;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_rdata;
  logic        int_taken;
  logic        hwint;
  logic        int_ack;
  logic        stuck_err;

  modport master (
    output int_in, bus_addr, bus_wdata, bus_byteen, int_taken,
    input  bus_rdata, hwint, int_ack, stuck_err
  );

  modport slave (
    input  int_in, bus_addr, bus_wdata, bus_byteen, int_taken,
    output bus_rdata, hwint, int_ack, stuck_err
  );
endinterface

// File: rtl/ext_int_responder_ack_timeout_ctr.sv
// Saturating up-counter with clear/load and a terminal-count flag; also used by the
// bridge watchdog.
module ack_timeout_ctr #(
  parameter int WIDTH    = 5,
  parameter int TERMINAL = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadVal_i,
  input  logic             inc_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= loadVal_i;
    end else if (inc_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/ext_int_responder.sv
// Holds an external interrupt as HWInt[2] until software acknowledges it by a store,
// then waits (bounded) for the source to release the line.
module ext_int_responder
  import ext_int_responder_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEFAULT,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  ext_int_responder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic             hwint_q, hwint_d;
  logic             intAck_q, intAck_d;
  logic             stuckErr_q, stuckErr_d;
  logic             enable_q, enable_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       spurious_q, spurious_d;

  logic [31:0] wordAddr;
  logic        isStore, ackSt, clrSt, enSt;
  logic        inAckWait, tmoTc;

  assign wordAddr  = wordAlign(bus.bus_addr);
  assign isStore   = |bus.bus_byteen;
  assign ackSt     = isStore && (wordAddr == ACK_ADDR + OFS_ACK);
  assign clrSt     = isStore && (wordAddr == ACK_ADDR + OFS_CNT);
  assign enSt      = bus.bus_byteen[0] && (wordAddr == ACK_ADDR + OFS_EN);
  assign inAckWait = (state_q == ST_ACK_WAIT);

  // Held at zero outside ACK_WAIT so every wait period starts counting from 0.
  ack_timeout_ctr #(
    .WIDTH   (TW),
    .TERMINAL(TIMEOUT - 1)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!inAckWait),
    .load_i   (1'b0),
    .loadVal_i('0),
    .inc_i    (inAckWait),
    .tc_o     (tmoTc)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    spurious_d = spurious_q;
    stuckErr_d = stuckErr_q;
    enable_d   = enable_q;
    intAck_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.int_in && enable_q) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (ackSt) begin
          state_d  = ST_ACK_WAIT;
          intAck_d = 1'b1;
          count_d  = count_q + 1'b1;
        end else if (bus.int_taken) begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (ackSt) begin
          state_d  = ST_ACK_WAIT;
          intAck_d = 1'b1;
          count_d  = count_q + 1'b1;
        end
      end
      ST_ACK_WAIT: begin
        if (!bus.int_in) begin
          state_d = ST_IDLE;
        end else if (tmoTc) begin
          stuckErr_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ackSt && (state_q == ST_IDLE || state_q == ST_ACK_WAIT) && spurious_q != 8'hFF)
      spurious_d = spurious_q + 1'b1;

    if (enSt) enable_d = bus.bus_wdata[0];

    // Clearing the statistics outranks any increment landing on the same edge.
    if (clrSt) begin
      count_d    = '0;
      spurious_d = '0;
      stuckErr_d = 1'b0;
    end

    hwint_d = (state_d == ST_PENDING) || (state_d == ST_SERVICE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hwint_q    <= 1'b0;
      intAck_q   <= 1'b0;
      stuckErr_q <= 1'b0;
      enable_q   <= 1'b1;
      count_q    <= '0;
      spurious_q <= '0;
    end else begin
      state_q    <= state_d;
      hwint_q    <= hwint_d;
      intAck_q   <= intAck_d;
      stuckErr_q <= stuckErr_d;
      enable_q   <= enable_d;
      count_q    <= count_d;
      spurious_q <= spurious_d;
    end
  end

  always_comb begin
    bus.bus_rdata = '0;
    if (wordAddr == ACK_ADDR + OFS_ACK)
      bus.bus_rdata = {27'b0, stuckErr_q, state_q, bus.int_in, hwint_q};
    else if (wordAddr == ACK_ADDR + OFS_CNT)
      bus.bus_rdata = 32'({spurious_q, count_q});
    else if (wordAddr == ACK_ADDR + OFS_EN)
      bus.bus_rdata = {31'b0, enable_q};
  end

  assign bus.hwint     = hwint_q;
  assign bus.int_ack   = intAck_q;
  assign bus.stuck_err = stuckErr_q;

endmodule

// File: tb/tb_ext_int_responder.sv
// Directed bench for ext_int_responder: handshake, polled ack, stuck source,
// spurious/clear, masking/reset and same-cycle races.
module tb_ext_int_responder;

  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;

  ext_int_responder_if ifc ();

  ext_int_responder dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    ifc.bus_byteen = 4'b0000;
    ifc.bus_addr   = addr;
    #1;
    data = ifc.bus_rdata;
  endtask

  task automatic busStore(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    ifc.bus_addr   = addr;
    ifc.bus_wdata  = data;
    ifc.bus_byteen = be;
    tick();
    ifc.bus_byteen = 4'b0000;
  endtask

  task automatic doReset();
    reset          = 1'b1;
    ifc.int_in     = 1'b0;
    ifc.int_taken  = 1'b0;
    ifc.bus_addr   = 32'h0;
    ifc.bus_wdata  = 32'h0;
    ifc.bus_byteen = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    doReset();
    nCompared++; if (ifc.hwint !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_hwint: got %b want 0", ifc.hwint); end
    nCompared++; if (ifc.int_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_int_ack: got %b want 0", ifc.int_ack); end
    nCompared++; if (ifc.stuck_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_stuck: got %b want 0", ifc.stuck_err); end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_status: got %h want 00000000", rd); end
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_counts: got %h want 00000000", rd); end
    busRead(32'h7F28, rd);
    nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL reset_enable: got %h want 00000001", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic        expHw, expAck;
    doReset();
    for (int c = 0; c <= 16; c++) begin
      ifc.int_in     = (c >= 5 && c < 15);
      ifc.int_taken  = (c == 9);
      ifc.bus_addr   = 32'h7F20;
      ifc.bus_byteen = (c == 14) ? 4'b1111 : 4'b0000;
      expHw  = (c >= 6 && c <= 14);
      expAck = (c == 15);
      nCompared++; if (ifc.hwint !== expHw) begin nMismatched++; $display("[TB] FAIL basic_hwint c%0d: got %b want %b", c, ifc.hwint, expHw); end
      nCompared++; if (ifc.int_ack !== expAck) begin nMismatched++; $display("[TB] FAIL basic_int_ack c%0d: got %b want %b", c, ifc.int_ack, expAck); end
      if (c == 16) begin
        busRead(32'h7F20, rd);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL basic_idle: got %h want 00000000", rd); end
      end
      tick();
    end
    ifc.int_taken = 1'b0;
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL basic_count: got %h want 00000001", rd); end
  endtask

  task automatic test_polled_ack();
    logic [31:0] rd;
    doReset();
    ifc.int_in = 1'b1;
    tick();
    nCompared++; if (ifc.hwint !== 1'b1) begin nMismatched++; $display("[TB] FAIL polled_hwint: got %b want 1", ifc.hwint); end
    tick();
    busStore(32'h7F22, 32'h0, 4'b0100);
    nCompared++; if (ifc.int_ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL polled_int_ack: got %b want 1", ifc.int_ack); end
    nCompared++; if (ifc.hwint !== 1'b0) begin nMismatched++; $display("[TB] FAIL polled_hwint_drop: got %b want 0", ifc.hwint); end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'hE) begin nMismatched++; $display("[TB] FAIL polled_ackwait: got %h want 0000000e", rd); end
    ifc.int_in = 1'b0;
    tick();
    nCompared++; if (ifc.int_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL polled_ack_len: got %b want 0", ifc.int_ack); end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL polled_idle: got %h want 00000000", rd); end
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL polled_count: got %h want 00000001", rd); end
  endtask

  task automatic test_stuck();
    logic [31:0] rd;
    doReset();
    ifc.int_in = 1'b1;
    tick();
    busStore(32'h7F20, 32'h0, 4'b1111);
    nCompared++; if (ifc.stuck_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL stuck_early j0: got %b want 0", ifc.stuck_err); end
    for (int j = 1; j <= 16; j++) begin
      tick();
      nCompared++; if (ifc.stuck_err !== (j == 16)) begin nMismatched++; $display("[TB] FAIL stuck_timing j%0d: got %b want %b", j, ifc.stuck_err, (j == 16)); end
    end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'h12) begin nMismatched++; $display("[TB] FAIL stuck_idle: got %h want 00000012", rd); end
    tick();
    nCompared++; if (ifc.hwint !== 1'b1) begin nMismatched++; $display("[TB] FAIL stuck_repend_hwint: got %b want 1", ifc.hwint); end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'h17) begin nMismatched++; $display("[TB] FAIL stuck_repend: got %h want 00000017", rd); end
    busStore(32'h7F24, 32'hFFFF_FFFF, 4'b1111);
    nCompared++; if (ifc.stuck_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL stuck_clear: got %b want 0", ifc.stuck_err); end
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL stuck_count_clear: got %h want 00000000", rd); end
  endtask

  task automatic test_spurious();
    logic [31:0] rd;
    doReset();
    for (int k = 0; k < 3; k++) begin
      busStore(32'h7F20, 32'h0, 4'b1111);
      nCompared++; if (ifc.int_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL spur_no_ack %0d: got %b want 0", k, ifc.int_ack); end
    end
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h0003_0000) begin nMismatched++; $display("[TB] FAIL spur_count3: got %h want 00030000", rd); end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL spur_state: got %h want 00000000", rd); end
    busStore(32'h7F24, 32'h0, 4'b0001);
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL spur_clear: got %h want 00000000", rd); end
    for (int k = 0; k < 257; k++) busStore(32'h7F20, 32'h0, 4'b1000);
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h00FF_0000) begin nMismatched++; $display("[TB] FAIL spur_saturate: got %h want 00ff0000", rd); end
  endtask

  task automatic test_mask_reset();
    logic [31:0] rd;
    doReset();
    busStore(32'h7F28, 32'h0, 4'b0010);
    busRead(32'h7F28, rd);
    nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL mask_needs_be0: got %h want 00000001", rd); end
    busStore(32'h7F28, 32'h0, 4'b0001);
    busRead(32'h7F28, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL mask_disable: got %h want 00000000", rd); end
    ifc.int_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      nCompared++; if (ifc.hwint !== 1'b0) begin nMismatched++; $display("[TB] FAIL mask_hwint %0d: got %b want 0", k, ifc.hwint); end
    end
    busStore(32'h7F28, 32'h1, 4'b0001);
    nCompared++; if (ifc.hwint !== 1'b0) begin nMismatched++; $display("[TB] FAIL mask_reenable_edge: got %b want 0", ifc.hwint); end
    tick();
    nCompared++; if (ifc.hwint !== 1'b1) begin nMismatched++; $display("[TB] FAIL mask_reenable_hwint: got %b want 1", ifc.hwint); end
    ifc.int_taken = 1'b1;
    tick();
    ifc.int_taken = 1'b0;
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'hB) begin nMismatched++; $display("[TB] FAIL mask_service: got %h want 0000000b", rd); end
    reset = 1'b1;
    tick();
    nCompared++; if (ifc.hwint !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_svc_hwint: got %b want 0", ifc.hwint); end
    nCompared++; if (ifc.int_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_svc_int_ack: got %b want 0", ifc.int_ack); end
    nCompared++; if (ifc.stuck_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_svc_stuck: got %b want 0", ifc.stuck_err); end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'h2) begin nMismatched++; $display("[TB] FAIL rst_svc_state: got %h want 00000002", rd); end
    reset      = 1'b0;
    ifc.int_in = 1'b0;
    tick();
  endtask

  task automatic test_races();
    logic [31:0] rd;
    doReset();
    ifc.int_in = 1'b1;
    tick();
    ifc.int_taken = 1'b1;
    busStore(32'h7F20, 32'h0, 4'b1111);
    ifc.int_taken = 1'b0;
    nCompared++; if (ifc.int_ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL race_int_ack: got %b want 1", ifc.int_ack); end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'hE) begin nMismatched++; $display("[TB] FAIL race_ackwait: got %h want 0000000e", rd); end
    tick();
    nCompared++; if (ifc.int_ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL race_single_pulse: got %b want 0", ifc.int_ack); end
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL race_count1: got %h want 00000001", rd); end
    ifc.int_in = 1'b0;
    tick();
    ifc.int_in = 1'b1;
    tick();
    ifc.int_in    = 1'b0;
    ifc.int_taken = 1'b1;
    tick();
    ifc.int_taken = 1'b0;
    nCompared++; if (ifc.hwint !== 1'b1) begin nMismatched++; $display("[TB] FAIL race_latched_hwint: got %b want 1", ifc.hwint); end
    busRead(32'h7F20, rd);
    nCompared++; if (rd !== 32'h9) begin nMismatched++; $display("[TB] FAIL race_latched_state: got %h want 00000009", rd); end
    busStore(32'h7F20, 32'h0, 4'b0001);
    nCompared++; if (ifc.int_ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL race_svc_ack: got %b want 1", ifc.int_ack); end
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h2) begin nMismatched++; $display("[TB] FAIL race_count2: got %h want 00000002", rd); end
    busStore(32'h7F24, 32'h0, 4'b1111);
    busRead(32'h7F24, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL race_clear: got %h want 00000000", rd); end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_basic();
    test_polled_ack();
    test_stuck();
    test_spurious();
    test_mask_reset();
    test_races();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
